// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the async FIFO: owns the read pointer and empty flag,
// and hides the memory's one-cycle read latency behind a 2-entry output buffer.
module fifo_rd_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk_i,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr_sync,
    input  logic [DATASIZE-1:0] mem_dout,
    output logic                ren,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic                fifo_empty,
    output logic [ADDRSIZE:0]   rptr,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready
);

    localparam int PW = ADDRSIZE + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]       rbin_r;
    logic [PW-1:0]       rptr_r;
    logic                fifo_empty_r;
    logic                rd_pending_r;
    logic [1:0]          count_r;
    logic                m_valid_r;
    logic [DATASIZE-1:0] head_r;
    logic [DATASIZE-1:0] tail_r;

    logic                pop_s;
    logic                ren_s;
    logic [2:0]          credit_s;
    logic [PW-1:0]       rbin_next_s;
    logic [PW-1:0]       rgray_next_s;
    logic [1:0]          count_next_s;
    logic [DATASIZE-1:0] head_next_s;
    logic [DATASIZE-1:0] tail_next_s;

    // Read issue: only request a word when buffer slots cover every in-flight read.
    always_comb begin
        pop_s    = m_valid_r & m_ready;
        credit_s = {1'b0, count_r} + {2'b00, rd_pending_r} - {2'b00, pop_s};
        if (!fifo_empty_r && (credit_s < 3'd2)) begin
            ren_s = 1'b1;
        end else begin
            ren_s = 1'b0;
        end
        rbin_next_s  = rbin_r + {{ADDRSIZE{1'b0}}, ren_s};
        rgray_next_s = bin2gray(rbin_next_s);
    end

    // Output buffer next state: append arriving memory data, shift on pop.
    always_comb begin
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        case ({rd_pending_r, pop_s})
            2'b10: begin
                count_next_s = count_r + 2'd1;
                if (count_r == 2'd0) begin
                    head_next_s = mem_dout;
                end else begin
                    tail_next_s = mem_dout;
                end
            end
            2'b01: begin
                count_next_s = count_r - 2'd1;
                head_next_s  = tail_r;
            end
            2'b11: begin
                // With one word held, the arriving word goes straight to the head.
                if (count_r == 2'd1) begin
                    head_next_s = mem_dout;
                end else begin
                    head_next_s = tail_r;
                    tail_next_s = mem_dout;
                end
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
    end

    // State registers; reset discards any in-flight read and buffered words.
    always_ff @(posedge rclk_i or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_r       <= {PW{1'b0}};
            rptr_r       <= {PW{1'b0}};
            fifo_empty_r <= 1'b1;
            rd_pending_r <= 1'b0;
            count_r      <= 2'd0;
            m_valid_r    <= 1'b0;
            head_r       <= {DATASIZE{1'b0}};
            tail_r       <= {DATASIZE{1'b0}};
        end else begin
            rbin_r       <= rbin_next_s;
            rptr_r       <= rgray_next_s;
            fifo_empty_r <= (rgray_next_s == wptr_sync);
            rd_pending_r <= ren_s;
            count_r      <= count_next_s;
            m_valid_r    <= (count_next_s != 2'd0);
            head_r       <= head_next_s;
            tail_r       <= tail_next_s;
        end
    end

    assign ren        = ren_s;
    assign rd_addr    = rbin_r[ADDRSIZE-1:0];
    assign fifo_empty = fifo_empty_r;
    assign rptr       = rptr_r;
    assign m_data     = head_r;
    assign m_valid    = m_valid_r;

    fifo_rd_ctrl_chk u_chk (
        .clk        (rclk_i),
        .rst_n      (rrst_n),
        .count      (count_r),
        .ren        (ren_s),
        .fifo_empty (fifo_empty_r)
    );

endmodule

// Invariant checks for the read controller.
module fifo_rd_ctrl_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] count,
    input logic       ren,
    input logic       fifo_empty
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count != 2'd3);
    a_ren_not_empty: assert property (@(posedge clk) disable iff (!rst_n) !(ren && fifo_empty));

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Single-clock read-side controller for the async FIFO. It drives the read port of `custom_fifomem` (`ren`, `rd_addr`, `fifo_empty`), owns the read pointer and the empty flag, and exports the Gray read pointer for synchronisation into the write domain. It absorbs the memory's 1-cycle registered read latency with a 2-entry output buffer, so the consumer sees a plain valid/ready stream with full throughput.

## Interface
Parameters:
- `DATASIZE`, 8, data word width; must match the memory.
- `ADDRSIZE`, 4, memory address bits; pointers are `ADDRSIZE+1` bits.

Ports:
- `rclk_i`  in  1  read-domain clock; all state changes on its rising edge.
- `rrst_n`  in  1  reset, asynchronous, active-low.
- `wptr_sync`  in  ADDRSIZE+1  Gray write pointer, already synchronised into `rclk_i`.
- `mem_dout`  in  DATASIZE  memory read data; valid only in the cycle after a `ren` edge, X otherwise.
- `ren`  out  1  memory read enable (combinational).
- `rd_addr`  out  ADDRSIZE  memory read address, equal to `rbin[ADDRSIZE-1:0]`.
- `fifo_empty`  out  1  registered empty flag; also drives the memory's `fifo_empty` input.
- `rptr`  out  ADDRSIZE+1  registered Gray read pointer for the write-side synchroniser.
- `m_data`  out  DATASIZE  head word of the output buffer.
- `m_valid`  out  1  output buffer is non-empty.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.

## Operation
- State:
  - `rbin`: binary read pointer, ADDRSIZE+1 bits.
  - `rptr = rbin ^ (rbin >> 1)`, registered.
  - `fifo_empty`.
  - `rd_pending`: a read was issued on the previous edge.
  - Output buffer: 2 entries, with `count` 0..2.
- `pop = m_valid & m_ready`.
- `ren = ~fifo_empty & ((count + rd_pending - pop) < 2)`. `ren` is never high while `fifo_empty=1`, so the memory's `ren & ~fifo_empty` gate is always satisfied when `ren` is asserted.
- Each edge:
  - `rbin <= rbin + ren`, modulo 2^(ADDRSIZE+1).
  - `rptr <= gray(rbin + ren)`.
  - `fifo_empty <= (gray(rbin + ren) == wptr_sync)`.
  - `rd_pending <= ren`.
- Buffer write: when `rd_pending=1`, `mem_dout` is appended at the tail. `mem_dout` is never sampled when `rd_pending=0`, so X data never enters the buffer.
- Simultaneous append and pop: `count` is unchanged and FIFO order is preserved. With `count=1` the appended word becomes the new head on the next edge.
- Overflow is impossible by construction: credit counts in-flight reads. A `count` of 3 is an assertion failure.
- Backpressure: while `m_valid & ~m_ready`, `m_data` holds stable.
- Pointer wrap: the MSB toggles every 2^ADDRSIZE reads. Empty is exact Gray equality, so wrap needs no special case.
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - `rbin=0`, `rptr=0`, `fifo_empty=1`, `rd_pending=0`, `count=0`, `m_valid=0`, `m_data=0`.
  - Therefore `ren=0` and `rd_addr=0`.
  - Reset mid-operation discards any in-flight read and all buffered words.

## Timing
- Cold start: `wptr_sync` changes before edge E0.
  - E0: `fifo_empty` falls.
  - Cycle E0–E1: `ren=1`, `rd_addr=rbin`.
  - E1: the memory registers the word, `rbin` increments, `rd_pending=1`.
  - E2: the word enters the buffer, and `m_valid=1` after E2.
  - Total: 3 edges from `wptr_sync` update to `m_valid`.
- Steady state with `m_ready=1`: `count=1` and `rd_pending=1`, giving one word per cycle with no bubbles.
- Stall: `m_ready=0` with `count=2`, or `count=1` with `rd_pending=1`, forces `ren=0`. Reads resume in the same cycle `m_ready` rises.
- The empty flag reflects a new `wptr_sync` after exactly 1 edge. Writes are seen late by the synchroniser depth, which is conservative and safe.

## Test plan
- Reset: hold `rrst_n=0` mid-clock -> immediately `fifo_empty=1`, `m_valid=0`, `ren=0`, `rptr=0`, `m_data=0`.
- Single word: `wptr_sync` goes 0 to gray(1)=1, memory[0]=0xA5, `m_ready=1` -> `ren` high for exactly 1 cycle, `m_valid` for 1 cycle with `m_data=0xA5` 3 edges after the update, `rptr`=1, `fifo_empty` returns to 1.
- Burst: 16 words 0x00..0x0F pre-written, `wptr_sync`=gray(16), `m_ready=1` -> 16 consecutive `m_valid` cycles with data in order, `rptr`=gray(16)=0x18.
- Backpressure: 8 words, `m_ready` toggling 1,0,0,1,… -> no loss or duplication, `m_data` stable while stalled, `count` never exceeds 2.
- Wrap-around: stream 40 words through with the writer keeping `wptr_sync` ahead -> `rd_addr` wraps 15 to 0, the `rptr` MSB toggles at read 16 and read 32, data in order.
- Reset mid-burst: assert `rrst_n` with `count=2` and `rd_pending=1` -> all state cleared, and after release no stale word appears on `m_data`.
